// File: rtl/fc_layer_sequencer.sv
// Sequencer for one fully-connected layer that time-shares a single MAC unit across all output neurons.
// Each neuron gets a bias load, IFM_DEPTH multiply-accumulates, a pipeline drain and one output write.
module fc_layer_sequencer #(
  parameter int IFM_DEPTH   = 84,
  parameter int NUM_NEURONS = 10,
  parameter int RD_LAT      = 1,
  parameter int MAC_LATENCY = 2,
  parameter int IN_ADDR_W   = $clog2(IFM_DEPTH),
  parameter int N_ADDR_W    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  parameter int WM_ADDR_W   = $clog2(IFM_DEPTH * NUM_NEURONS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 ready_to_previous,
  output logic                 ifm_rd_en,
  output logic [IN_ADDR_W-1:0] ifm_addr,
  output logic                 wm_rd_en,
  output logic [WM_ADDR_W-1:0] wm_addr,
  output logic                 bias_rd_en,
  output logic [N_ADDR_W-1:0]  bias_addr,
  output logic                 mac_load_bias,
  output logic                 mac_acc_en,
  input  logic                 next_ready,
  output logic                 ofm_wr_en,
  output logic [N_ADDR_W-1:0]  ofm_wr_addr,
  output logic                 layer_done
);

  localparam int DRAIN_LEN = RD_LAT + MAC_LATENCY;
  localparam int DRAIN_W   = $clog2(DRAIN_LEN) + 1;
  localparam logic [IN_ADDR_W-1:0] I_LAST     = IN_ADDR_W'(IFM_DEPTH - 1);
  localparam logic [N_ADDR_W-1:0]  N_LAST     = N_ADDR_W'(NUM_NEURONS - 1);
  localparam logic [DRAIN_W-1:0]   DRAIN_INIT = DRAIN_W'(DRAIN_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_ACC, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [IN_ADDR_W-1:0] i_cnt;
  logic [N_ADDR_W-1:0]  n_cnt;
  logic [WM_ADDR_W-1:0] wm_cnt;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic [RD_LAT-1:0]    bias_vld_p;
  logic [RD_LAT-1:0]    acc_vld_p;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    ready_to_previous = 1'b0;
    ifm_rd_en         = 1'b0;
    wm_rd_en          = 1'b0;
    bias_rd_en        = 1'b0;
    ofm_wr_en         = 1'b0;
    layer_done        = 1'b0;
    case (state)
      S_IDLE: begin
        ready_to_previous = 1'b1;
        if (start) state_nxt = S_BIAS;
      end
      S_BIAS: begin
        bias_rd_en = 1'b1;
        state_nxt  = S_ACC;
      end
      S_ACC: begin
        ifm_rd_en = 1'b1;
        wm_rd_en  = 1'b1;
        if (i_cnt == I_LAST) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt == '0) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        ofm_wr_en = next_ready;
        if (next_ready) state_nxt = (n_cnt == N_LAST) ? S_DONE : S_BIAS;
      end
      S_DONE: begin
        layer_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // wm_cnt runs across neurons, so it lands on (n+1)*IFM_DEPTH without a multiplier
  always_ff @(posedge clk) begin
    if (!reset) begin
      i_cnt     <= '0;
      n_cnt     <= '0;
      wm_cnt    <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            i_cnt  <= '0;
            n_cnt  <= '0;
            wm_cnt <= '0;
          end
        end
        S_ACC: begin
          wm_cnt <= wm_cnt + WM_ADDR_W'(1);
          if (i_cnt == I_LAST) begin
            i_cnt     <= '0;
            drain_cnt <= DRAIN_INIT;
          end else begin
            i_cnt <= i_cnt + IN_ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt != '0) drain_cnt <= drain_cnt - DRAIN_W'(1);
        end
        S_WRITE: begin
          if (next_ready && (n_cnt != N_LAST)) n_cnt <= n_cnt + N_ADDR_W'(1);
        end
        S_DONE: begin
          n_cnt  <= '0;
          wm_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Read-latency alignment: stage p0 captures the strobe, stage p(RD_LAT-1) drives the MAC
  always_ff @(posedge clk) begin
    if (!reset) begin
      bias_vld_p <= '0;
      acc_vld_p  <= '0;
    end else begin
      bias_vld_p[0] <= bias_rd_en;
      acc_vld_p[0]  <= ifm_rd_en;
      for (int k = 1; k < RD_LAT; k++) begin
        bias_vld_p[k] <= bias_vld_p[k-1];
        acc_vld_p[k]  <= acc_vld_p[k-1];
      end
    end
  end

  assign mac_load_bias = bias_vld_p[RD_LAT-1];
  assign mac_acc_en    = acc_vld_p[RD_LAT-1];
  assign ifm_addr      = i_cnt;
  assign wm_addr       = wm_cnt;
  assign bias_addr     = n_cnt;
  assign ofm_wr_addr   = n_cnt;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer: default (84x10) and small (4x2) instances checked
// cycle by cycle against a schedule-level model of the layer timing.
module tb_fc_layer_sequencer;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, next_ready, sel;
  logic start_d, start_s;
  assign start_d = start & ~sel;
  assign start_s = start & sel;

  // default instance
  logic       d_ready, d_ifm, d_wm, d_bias, d_lb, d_acc, d_wr, d_done;
  logic [6:0] d_ia;
  logic [9:0] d_wa;
  logic [3:0] d_ba, d_wra;
  // small instance
  logic       s_ready, s_ifm, s_wm, s_bias, s_lb, s_acc, s_wr, s_done;
  logic [1:0] s_ia;
  logic [2:0] s_wa;
  logic [0:0] s_ba, s_wra;

  fc_layer_sequencer dut (
    .clk(clk), .reset(reset), .start(start_d), .ready_to_previous(d_ready),
    .ifm_rd_en(d_ifm), .ifm_addr(d_ia), .wm_rd_en(d_wm), .wm_addr(d_wa),
    .bias_rd_en(d_bias), .bias_addr(d_ba), .mac_load_bias(d_lb), .mac_acc_en(d_acc),
    .next_ready(next_ready), .ofm_wr_en(d_wr), .ofm_wr_addr(d_wra), .layer_done(d_done)
  );

  fc_layer_sequencer #(.IFM_DEPTH(4), .NUM_NEURONS(2), .RD_LAT(1), .MAC_LATENCY(1)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .ready_to_previous(s_ready),
    .ifm_rd_en(s_ifm), .ifm_addr(s_ia), .wm_rd_en(s_wm), .wm_addr(s_wa),
    .bias_rd_en(s_bias), .bias_addr(s_ba), .mac_load_bias(s_lb), .mac_acc_en(s_acc),
    .next_ready(next_ready), .ofm_wr_en(s_wr), .ofm_wr_addr(s_wra), .layer_done(s_done)
  );

  logic o_ready, o_ifm, o_wm, o_bias, o_lb, o_acc, o_wr, o_done;
  int   o_ia, o_wa, o_ba, o_wra;
  always_comb begin
    if (sel) begin
      {o_ready, o_ifm, o_wm, o_bias, o_lb, o_acc, o_wr, o_done} =
        {s_ready, s_ifm, s_wm, s_bias, s_lb, s_acc, s_wr, s_done};
      o_ia = int'(s_ia); o_wa = int'(s_wa); o_ba = int'(s_ba); o_wra = int'(s_wra);
    end else begin
      {o_ready, o_ifm, o_wm, o_bias, o_lb, o_acc, o_wr, o_done} =
        {d_ready, d_ifm, d_wm, d_bias, d_lb, d_acc, d_wr, d_done};
      o_ia = int'(d_ia); o_wa = int'(d_wa); o_ba = int'(d_ba); o_wra = int'(d_wra);
    end
  end

  int checks = 0;
  int passed = 0;

  // stimulus, model expectations and observations, indexed by cycle
  bit st[MAXC];
  bit nr[MAXC];
  int rst_c;
  bit e_ready[MAXC], e_bias[MAXC], e_ifm[MAXC], e_lb[MAXC], e_acc[MAXC], e_wr[MAXC], e_done[MAXC];
  int e_ia[MAXC], e_wa[MAXC], e_ba[MAXC], e_wra[MAXC];
  bit ob_ready[MAXC], ob_wr[MAXC], ob_done[MAXC], ob_lb[MAXC], ob_acc[MAXC];
  int ob_wra[MAXC];
  int mD, mN, mRD, mML;
  int mm;
  string mm_msg;

  task automatic set_cfg(input bit s);
    sel = s;
    if (s) begin mD = 4;  mN = 2;  mRD = 1; mML = 1; end
    else   begin mD = 84; mN = 10; mRD = 1; mML = 2; end
  endtask

  task automatic clear_stim();
    for (int k = 0; k < MAXC; k++) begin st[k] = 1'b0; nr[k] = 1'b1; end
    rst_c = -1;
  endtask

  task automatic do_reset();
    start = 1'b0; next_ready = 1'b1; reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Layer schedule: idle until a start, then per neuron a bias cycle, mD reads,
  // mRD+mML drain cycles and a write that waits for next_ready; done follows the last write.
  task automatic build_model(input int L);
    int c, b, w;
    for (int k = 0; k < MAXC; k++) begin
      e_ready[k] = 0; e_bias[k] = 0; e_ifm[k] = 0; e_lb[k] = 0; e_acc[k] = 0;
      e_wr[k] = 0; e_done[k] = 0; e_ia[k] = 0; e_wa[k] = 0; e_ba[k] = 0; e_wra[k] = 0;
    end
    c = 0;
    while (c < L) begin
      if (st[c] && c != rst_c) begin
        e_ready[c] = 1;
        b = c + 1;
        for (int n = 0; n < mN; n++) begin
          e_bias[b] = 1; e_ba[b] = n; e_lb[b + mRD] = 1;
          for (int k = 0; k < mD; k++) begin
            e_ifm[b+1+k] = 1; e_ia[b+1+k] = k; e_wa[b+1+k] = n * mD + k;
            e_acc[b+1+k+mRD] = 1;
          end
          w = b + 1 + mD + mRD + mML;
          while (!nr[w] && w < MAXC - 4) w++;
          e_wr[w] = 1; e_wra[w] = n;
          b = w + 1;
        end
        e_done[b] = 1;
        if (rst_c > c && rst_c <= b) begin
          for (int k = rst_c + 1; k <= b + mRD + 1; k++) begin
            e_bias[k] = 0; e_ifm[k] = 0; e_lb[k] = 0; e_acc[k] = 0; e_wr[k] = 0; e_done[k] = 0;
          end
          c = rst_c + 1;
        end else begin
          c = b + 1;
        end
      end else begin
        e_ready[c] = 1;
        c++;
      end
    end
  endtask

  // Drives L cycles from an idle cycle 0 and records per-cycle deviations from the model.
  task automatic run_seq(input int L);
    logic [7:0] act, expv;
    build_model(L);
    mm = 0; mm_msg = "none";
    for (int c = 0; c < L; c++) begin
      start = st[c]; next_ready = nr[c]; reset = (c == rst_c) ? 1'b0 : 1'b1;
      @(negedge clk);
      act  = {o_ready, o_bias, o_ifm, o_wm, o_lb, o_acc, o_wr, o_done};
      expv = {e_ready[c], e_bias[c], e_ifm[c], e_ifm[c], e_lb[c], e_acc[c], e_wr[c], e_done[c]};
      if (act !== expv) begin
        if (mm == 0) mm_msg = $sformatf("strobes cyc %0d got %b expected %b", c, act, expv);
        mm++;
      end
      if (o_ifm && (o_ia !== e_ia[c] || o_wa !== e_wa[c])) begin
        if (mm == 0) mm_msg = $sformatf("ifm/wm addr cyc %0d got %0d/%0d expected %0d/%0d",
                                        c, o_ia, o_wa, e_ia[c], e_wa[c]);
        mm++;
      end
      if (o_bias && o_ba !== e_ba[c]) begin
        if (mm == 0) mm_msg = $sformatf("bias_addr cyc %0d got %0d expected %0d", c, o_ba, e_ba[c]);
        mm++;
      end
      if (o_wr && o_wra !== e_wra[c]) begin
        if (mm == 0) mm_msg = $sformatf("ofm_wr_addr cyc %0d got %0d expected %0d", c, o_wra, e_wra[c]);
        mm++;
      end
      ob_ready[c] = o_ready; ob_wr[c] = o_wr; ob_wra[c] = o_wra; ob_done[c] = o_done;
      ob_lb[c] = o_lb; ob_acc[c] = o_acc;
      @(posedge clk); #1;
    end
    start = 1'b0; reset = 1'b1; next_ready = 1'b1;
  endtask

  function automatic int count_wr(input int L);
    int n = 0;
    for (int k = 0; k < L; k++) if (ob_wr[k]) n++;
    return n;
  endfunction

  function automatic int count_done(input int L);
    int n = 0;
    for (int k = 0; k < L; k++) if (ob_done[k]) n++;
    return n;
  endfunction

  task automatic test_reset();
    logic [6:0] strb;
    set_cfg(0);
    start = 1'b1; next_ready = 1'b1; reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    strb = {o_ifm, o_wm, o_bias, o_wr, o_done, o_lb, o_acc};
    checks++; if (o_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", o_ready); else passed++;
    checks++; if (strb !== 7'b0) $display("FAIL reset_strobes: got %b expected 0000000", strb); else passed++;
    checks++;
    if ({o_ia, o_wa, o_ba, o_wra} !== 128'd0)
      $display("FAIL reset_addrs: got %0d/%0d/%0d/%0d expected 0/0/0/0", o_ia, o_wa, o_ba, o_wra);
    else passed++;
    // start a layer, abort it mid-accumulation
    @(posedge clk); #1; reset = 1'b1;
    repeat (40) @(posedge clk);
    #1; start = 1'b0;
    @(negedge clk);
    checks++; if (o_ifm !== 1'b1) $display("FAIL reset_pre_acc: got %b expected 1", o_ifm); else passed++;
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    strb = {o_ifm, o_wm, o_bias, o_wr, o_done, o_lb, o_acc};
    checks++; if (strb !== 7'b0) $display("FAIL abort_strobes: got %b expected 0000000", strb); else passed++;
    checks++; if (o_ready !== 1'b1) $display("FAIL abort_ready: got %b expected 1", o_ready); else passed++;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({o_ready, o_bias} !== 2'b10) $display("FAIL abort_stays_idle: got %b expected 10", {o_ready, o_bias});
    else passed++;
  endtask

  task automatic test_single_layer();
    int first;
    set_cfg(0); do_reset(); clear_stim();
    st[0] = 1;
    run_seq(950);
    checks++; if (mm !== 0) $display("FAIL single_model: %0d deviations, first %s", mm, mm_msg); else passed++;
    checks++; if (count_wr(950) !== 10) $display("FAIL single_wr_count: got %0d expected 10", count_wr(950)); else passed++;
    first = -1;
    for (int k = 949; k >= 0; k--) if (ob_wr[k]) first = k;
    checks++; if (first !== 89) $display("FAIL single_first_wr: got cycle %0d expected 89", first); else passed++;
    checks++;
    if (!ob_wr[890] || ob_wra[890] !== 9) $display("FAIL single_last_wr: got %b addr %0d expected 1 addr 9", ob_wr[890], ob_wra[890]);
    else passed++;
    checks++; if (ob_done[891] !== 1'b1) $display("FAIL single_done: got %b at 891 expected 1", ob_done[891]); else passed++;
    checks++;
    if ({ob_ready[891], ob_ready[892]} !== 2'b01) $display("FAIL single_ready_back: got %b expected 01", {ob_ready[891], ob_ready[892]});
    else passed++;
  endtask

  task automatic test_small_config();
    set_cfg(1); do_reset(); clear_stim();
    st[0] = 1;
    run_seq(30);
    checks++; if (mm !== 0) $display("FAIL small_model: %0d deviations, first %s", mm, mm_msg); else passed++;
    checks++; if (ob_done[17] !== 1'b1 || count_done(30) !== 1) $display("FAIL small_done: got %b at 17, count %0d expected 1, 1", ob_done[17], count_done(30)); else passed++;
    checks++;
    if ({ob_lb[1], ob_lb[2], ob_lb[10]} !== 3'b011) $display("FAIL small_load_bias: got %b expected 011", {ob_lb[1], ob_lb[2], ob_lb[10]});
    else passed++;
    checks++;
    if ({ob_acc[2], ob_acc[3], ob_acc[6], ob_acc[7]} !== 4'b0110)
      $display("FAIL small_acc_align: got %b expected 0110", {ob_acc[2], ob_acc[3], ob_acc[6], ob_acc[7]});
    else passed++;
    set_cfg(0);
  endtask

  task automatic test_stall();
    set_cfg(0); do_reset(); clear_stim();
    st[0] = 1;
    for (int k = 267; k < 272; k++) nr[k] = 0;
    run_seq(950);
    checks++; if (mm !== 0) $display("FAIL stall_model: %0d deviations, first %s", mm, mm_msg); else passed++;
    checks++;
    if (ob_wr[267] !== 1'b0 || ob_wr[272] !== 1'b1 || ob_wra[272] !== 2)
      $display("FAIL stall_write: got %b/%b addr %0d expected 0/1 addr 2", ob_wr[267], ob_wr[272], ob_wra[272]);
    else passed++;
    checks++; if (count_wr(950) !== 10) $display("FAIL stall_wr_count: got %0d expected 10", count_wr(950)); else passed++;
    checks++; if (ob_done[896] !== 1'b1) $display("FAIL stall_done: got %b at 896 expected 1", ob_done[896]); else passed++;
  endtask

  task automatic test_spurious_start();
    set_cfg(0); do_reset(); clear_stim();
    st[0] = 1; st[10] = 1; st[500] = 1;
    run_seq(950);
    checks++; if (mm !== 0) $display("FAIL spurious_model: %0d deviations, first %s", mm, mm_msg); else passed++;
    checks++; if (count_done(950) !== 1) $display("FAIL spurious_done_count: got %0d expected 1", count_done(950)); else passed++;
    checks++; if (count_wr(950) !== 10) $display("FAIL spurious_wr_count: got %0d expected 10", count_wr(950)); else passed++;
  endtask

  task automatic test_reset_mid();
    set_cfg(0); do_reset(); clear_stim();
    st[0] = 1; rst_c = 300; st[400] = 1;
    run_seq(1300);
    checks++; if (mm !== 0) $display("FAIL rstmid_model: %0d deviations, first %s", mm, mm_msg); else passed++;
    checks++; if (count_wr(1300) !== 13) $display("FAIL rstmid_wr_count: got %0d expected 13", count_wr(1300)); else passed++;
    checks++;
    if (!ob_wr[489] || ob_wra[489] !== 0) $display("FAIL rstmid_restart: got %b addr %0d expected 1 addr 0", ob_wr[489], ob_wra[489]);
    else passed++;
    checks++;
    if (count_done(1300) !== 1 || ob_done[1291] !== 1'b1)
      $display("FAIL rstmid_done: got count %0d at1291 %b expected 1, 1", count_done(1300), ob_done[1291]);
    else passed++;
  endtask

  task automatic test_back_to_back();
    set_cfg(0); do_reset(); clear_stim();
    for (int k = 0; k < 1800; k++) st[k] = 1;
    run_seq(1800);
    checks++; if (mm !== 0) $display("FAIL b2b_model: %0d deviations, first %s", mm, mm_msg); else passed++;
    checks++;
    if ({ob_done[891], ob_done[1783]} !== 2'b11 || count_done(1800) !== 2)
      $display("FAIL b2b_done: got %b count %0d expected 11 count 2", {ob_done[891], ob_done[1783]}, count_done(1800));
    else passed++;
    checks++;
    if ({ob_ready[891], ob_ready[892], ob_ready[893]} !== 3'b010)
      $display("FAIL b2b_ready_gap: got %b expected 010", {ob_ready[891], ob_ready[892], ob_ready[893]});
    else passed++;
    checks++; if (count_wr(1800) !== 20) $display("FAIL b2b_wr_count: got %0d expected 20", count_wr(1800)); else passed++;
  endtask

  task automatic test_random();
    int L, ewr;
    for (int r = 0; r < 4; r++) begin
      set_cfg(r >= 2); do_reset(); clear_stim();
      L = (r >= 2) ? 400 : 2500;
      for (int k = 0; k < L; k++) begin
        st[k] = ($urandom_range(0, 49) == 0);
        nr[k] = ($urandom_range(0, 3) != 0);
      end
      st[0] = 1;
      if (r == 3) rst_c = $urandom_range(40, 300);
      run_seq(L);
      ewr = 0;
      for (int k = 0; k < L; k++) if (e_wr[k]) ewr++;
      checks++; if (mm !== 0) $display("FAIL random%0d_model: %0d deviations, first %s", r, mm, mm_msg); else passed++;
      checks++;
      if (count_wr(L) !== ewr) $display("FAIL random%0d_wr_count: got %0d expected %0d", r, count_wr(L), ewr);
      else passed++;
    end
    set_cfg(0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; next_ready = 1'b1;
    set_cfg(0);
    test_reset();
    test_single_layer();
    test_small_config();
    test_stall();
    test_spurious_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
